io_bus_initiator: RTL and testbench

Bus initiator for the 8-bit memory-mapped I/O bus. It sits between the CPU core's load/store path and the I/O peripheral block. It accepts one command at a time over a valid/ready handshake and drives a single-cycle read or write strobe on the peripheral bus. It then returns the captured data and a status bit over a second valid/ready handshake.

---
 rtl/io_bus_initiator_if.sv | 31 +++
 rtl/io_bus_initiator.sv | 181 ++++++++++++++++++
 tb/tb_io_bus_initiator.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_initiator_if.sv
// Handshake and peripheral-bus bundle for io_bus_initiator.
// master is the initiator's view; slave is the core/peripheral side.
interface io_bus_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_mask;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] bus_addr;
  logic [7:0] bus_write_data;
  logic       bus_write_en;
  logic       bus_read_en;
  logic [7:0] bus_read_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, bus_read_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           bus_addr, bus_write_data, bus_write_en, bus_read_en
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, bus_read_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           bus_addr, bus_write_data, bus_write_en, bus_read_en
  );
endinterface

// File: rtl/io_bus_initiator.sv
// Single-outstanding initiator for the 8-bit memory-mapped I/O bus.
// Define IO_POLL_EN to compile in the poll op, POLL_WAIT state and poll counters.
module io_bus_initiator #(
  parameter int POLL_TIMEOUT  = 255,
  parameter int POLL_INTERVAL = 4
) (
  input logic                clk,
  input logic                reset,
  io_bus_initiator_if.master bus
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    POLL_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t     state_r;
  logic [1:0] op_r;
  logic       accept_s;
  logic       op_ok_s;

  assign accept_s = bus.cmd_valid && bus.cmd_ready;

`ifdef IO_POLL_EN
  localparam logic [7:0] TIMEOUT_C  = 8'(POLL_TIMEOUT);
  localparam logic [3:0] INTERVAL_C = 4'(POLL_INTERVAL);

  logic [7:0] mask_r;
  logic [7:0] cnt_r;
  logic [3:0] wait_r;
  logic       poll_match_s;
  logic [7:0] cnt_next_s;

  // The registered write data doubles as the poll compare value.
  assign poll_match_s = ((bus.bus_read_data & mask_r) == (bus.bus_write_data & mask_r));
  assign cnt_next_s   = cnt_r + 8'd1;
`else
  logic unused_poll_cfg_s;
  assign unused_poll_cfg_s = ^{bus.cmd_mask, 32'(POLL_TIMEOUT), 32'(POLL_INTERVAL)};
`endif

  // Decode which ops issue a bus access; everything else answers as reserved.
  always_comb begin
    op_ok_s = 1'b0;
    case (bus.cmd_op)
      OP_READ:  op_ok_s = 1'b1;
      OP_WRITE: op_ok_s = 1'b1;
`ifdef IO_POLL_EN
      OP_POLL:  op_ok_s = 1'b1;
`endif
      default:  op_ok_s = 1'b0;
    endcase
  end

  // Command FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= IDLE;
      op_r               <= 2'b00;
      bus.cmd_ready      <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_data       <= 8'h00;
      bus.rsp_err        <= 1'b0;
      bus.bus_addr       <= 8'h00;
      bus.bus_write_data <= 8'h00;
      bus.bus_write_en   <= 1'b0;
      bus.bus_read_en    <= 1'b0;
`ifdef IO_POLL_EN
      mask_r             <= 8'h00;
      cnt_r              <= 8'h00;
      wait_r             <= 4'h0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r               <= bus.cmd_op;
            bus.bus_addr       <= bus.cmd_addr;
            bus.bus_write_data <= bus.cmd_wdata;
            bus.cmd_ready      <= 1'b0;
`ifdef IO_POLL_EN
            mask_r             <= bus.cmd_mask;
            cnt_r              <= 8'h00;
`endif
            if (op_ok_s) begin
              state_r          <= ACCESS;
              bus.bus_write_en <= (bus.cmd_op == OP_WRITE);
              bus.bus_read_en  <= (bus.cmd_op != OP_WRITE);
            end else begin
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= 8'h00;
            end
          end
        end

        ACCESS: begin
          bus.bus_write_en <= 1'b0;
          bus.bus_read_en  <= 1'b0;
          case (op_r)
            OP_READ: begin
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= bus.bus_read_data;
              bus.rsp_err   <= 1'b0;
            end
            OP_WRITE: begin
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= 8'h00;
              bus.rsp_err   <= 1'b0;
            end
`ifdef IO_POLL_EN
            OP_POLL: begin
              // Keep the latest sample so a timeout reports the last value read.
              bus.rsp_data <= bus.bus_read_data;
              cnt_r        <= cnt_next_s;
              if (poll_match_s) begin
                state_r       <= RESP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b0;
              end else if (cnt_next_s >= TIMEOUT_C) begin
                state_r       <= RESP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
              end else if (INTERVAL_C == 4'd0) begin
                state_r         <= ACCESS;
                bus.bus_read_en <= 1'b1;
              end else begin
                state_r <= POLL_WAIT;
                wait_r  <= INTERVAL_C - 4'd1;
              end
            end
`endif
            default: begin
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= 8'h00;
              bus.rsp_err   <= 1'b1;
            end
          endcase
        end

`ifdef IO_POLL_EN
        POLL_WAIT: begin
          if (wait_r == 4'd0) begin
            state_r         <= ACCESS;
            bus.bus_read_en <= 1'b1;
          end else begin
            wait_r <= wait_r - 4'd1;
          end
        end
`endif

        RESP: begin
          if (bus.rsp_ready) begin
            state_r       <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end

        default: begin
          state_r          <= IDLE;
          bus.cmd_ready    <= 1'b1;
          bus.rsp_valid    <= 1'b0;
          bus.bus_write_en <= 1'b0;
          bus.bus_read_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed, table-driven bench for io_bus_initiator with a small peripheral model
// (register file, switches at 0x04, LEDs = low nibble of register 0x00).
module tb_io_bus_initiator;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [7:0] switches;
  logic [7:0] regs [0:255];

  io_bus_initiator_if bif ();

  io_bus_initiator #(
    .POLL_TIMEOUT (4),
    .POLL_INTERVAL(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bif.bus_read_data = bif.bus_read_en ?
                             ((bif.bus_addr == 8'h04) ? switches : regs[bif.bus_addr]) : 8'h00;

  always @(posedge clk) begin
    if (bif.bus_write_en) regs[bif.bus_addr] <= bif.bus_write_data;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mask;
    logic [7:0] sw;
    int         flip_after;
    int         exp_w;
    int         exp_r;
    int         exp_lat;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] mask);
    bif.cmd_op    = op;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wdata;
    bif.cmd_mask  = mask;
    bif.cmd_valid = 1'b1;
  endtask

  task automatic handshake();
    bif.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bif.rsp_ready = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_hs", bif.cmd_ready, 1'b1);
    check("rsp_valid_after_hs", bif.rsp_valid, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v);
    int nw;
    int nr;
    int lat;
    nw  = 0;
    nr  = 0;
    lat = 0;
    @(negedge clk);
    switches = v.sw;
    check("cmd_ready_idle", bif.cmd_ready, 1'b1);
    drive_cmd(v.op, v.addr, v.wdata, v.mask);
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (bif.rsp_valid) begin
        lat = k;
      end else begin
        if (bif.bus_write_en && bif.bus_read_en)
          check("strobe_overlap", {bif.bus_write_en, bif.bus_read_en}, 2'b01);
        if (bif.bus_write_en) begin
          nw++;
          check("wr_addr", bif.bus_addr, v.addr);
          check("wr_data", bif.bus_write_data, v.wdata);
        end
        if (bif.bus_read_en) begin
          nr++;
          check("rd_addr", bif.bus_addr, v.addr);
        end
        if (v.flip_after > 0 && nr == v.flip_after && !bif.bus_read_en)
          switches = switches | 8'h01;
      end
    end
    if (lat == 0) begin
      check("rsp_timeout", bif.rsp_valid, 1'b1);
    end else begin
      check("latency", lat, v.exp_lat);
      check("write_strobes", nw, v.exp_w);
      check("read_strobes", nr, v.exp_r);
      check("rsp_data", bif.rsp_data, v.exp_data);
      check("rsp_err", bif.rsp_err, v.exp_err);
      check("bus_addr_held", bif.bus_addr, v.addr);
      check("strobes_in_resp", {bif.bus_write_en, bif.bus_read_en}, 2'b00);
      check("cmd_ready_in_resp", bif.cmd_ready, 1'b0);
      handshake();
    end
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 50 && !bif.rsp_valid; k++) @(negedge clk);
    check("wait_rsp_valid", bif.rsp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    switches = 8'h09;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 2'b00;
    bif.cmd_addr  = 8'h00;
    bif.cmd_wdata = 8'h00;
    bif.cmd_mask  = 8'h00;
    bif.rsp_ready = 1'b0;

    //            op     addr   wdata  mask   sw     flip w  r  lat data   err
    vecs[0] = '{2'b01, 8'h00, 8'hA5, 8'h00, 8'h09, 0, 1, 0, 2, 8'h00, 1'b0};
    vecs[1] = '{2'b00, 8'h04, 8'h00, 8'h00, 8'h09, 0, 0, 1, 2, 8'h09, 1'b0};
    vecs[2] = '{2'b01, 8'h10, 8'h3C, 8'h00, 8'h09, 0, 1, 0, 2, 8'h00, 1'b0};
    vecs[3] = '{2'b00, 8'h10, 8'h00, 8'h00, 8'h09, 0, 0, 1, 2, 8'h3C, 1'b0};
    vecs[4] = '{2'b11, 8'h20, 8'hFF, 8'h00, 8'h09, 0, 0, 0, 1, 8'h00, 1'b1};
    vecs[5] = '{2'b00, 8'h04, 8'h00, 8'h00, 8'hF0, 0, 0, 1, 2, 8'hF0, 1'b0};
`ifdef IO_POLL_EN
    vecs[6] = '{2'b10, 8'h04, 8'h01, 8'h01, 8'h08, 2, 0, 3, 8, 8'h09, 1'b0};
    vecs[7] = '{2'b10, 8'h04, 8'h01, 8'h01, 8'h08, 0, 0, 4, 11, 8'h08, 1'b1};
    vecs[8] = '{2'b10, 8'h04, 8'h80, 8'hF0, 8'h8F, 0, 0, 1, 2, 8'h8F, 1'b0};
`else
    vecs[6] = '{2'b10, 8'h04, 8'h01, 8'h01, 8'h08, 2, 0, 0, 1, 8'h00, 1'b1};
    vecs[7] = '{2'b10, 8'h04, 8'h01, 8'h01, 8'h08, 0, 0, 0, 1, 8'h00, 1'b1};
    vecs[8] = '{2'b10, 8'h04, 8'h80, 8'hF0, 8'h8F, 0, 0, 0, 1, 8'h00, 1'b1};
`endif

    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bif.cmd_ready, 1'b1);
    check("rst_rsp_valid", bif.rsp_valid, 1'b0);
    check("rst_rsp_data", bif.rsp_data, 8'h00);
    check("rst_rsp_err", bif.rsp_err, 1'b0);
    check("rst_bus_addr", bif.bus_addr, 8'h00);
    check("rst_bus_wdata", bif.bus_write_data, 8'h00);
    check("rst_strobes", {bif.bus_write_en, bif.bus_read_en}, 2'b00);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply_vec(vecs[i]);
      if (i == 0) check("leds", {28'h0, regs[0][3:0]}, 32'h5);
    end

    // Back-pressure on a read, then a write accepted in the first free cycle.
    @(negedge clk);
    switches = 8'h5A;
    drive_cmd(2'b00, 8'h04, 8'h00, 8'h00);
    @(posedge clk);
    #1 drive_cmd(2'b01, 8'h20, 8'h77, 8'h00);
    @(negedge clk);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", bif.rsp_valid, 1'b1);
      check("bp_rsp_data", bif.rsp_data, 8'h5A);
      check("bp_rsp_err", bif.rsp_err, 1'b0);
      check("bp_cmd_ready", bif.cmd_ready, 1'b0);
      check("bp_strobes", {bif.bus_write_en, bif.bus_read_en}, 2'b00);
      @(negedge clk);
    end
    bif.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bif.rsp_ready = 1'b0;
    @(negedge clk);
    check("b2b_cmd_ready", bif.cmd_ready, 1'b1);
    check("b2b_no_strobe_yet", bif.bus_write_en, 1'b0);
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_write_en", bif.bus_write_en, 1'b1);
    check("b2b_write_data", bif.bus_write_data, 8'h77);
    @(negedge clk);
    check("b2b_rsp_valid", bif.rsp_valid, 1'b1);
    check("b2b_rsp_data", bif.rsp_data, 8'h00);
    handshake();

    // Reset mid-operation: no response and no further strobes.
    switches = 8'h08;
`ifdef IO_POLL_EN
    drive_cmd(2'b10, 8'h04, 8'h01, 8'h01);
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_in_wait", bif.bus_read_en, 1'b0);
`else
    drive_cmd(2'b00, 8'h30, 8'h00, 8'h00);
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_strobe", bif.bus_read_en, 1'b1);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_cmd_ready", bif.cmd_ready, 1'b1);
    check("rst_mid_bus_addr", bif.bus_addr, 8'h00);
    check("rst_mid_rsp_data", bif.rsp_data, 8'h00);
    for (int k = 0; k < 8; k++) begin
      check("rst_mid_no_rsp", bif.rsp_valid, 1'b0);
      check("rst_mid_no_strobe", {bif.bus_write_en, bif.bus_read_en}, 2'b00);
      @(negedge clk);
    end

    apply_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
